// File: rtl/estagio_ula_pkg.sv
// Dual-rail constants, opcodes, FSM state types and bit-pair helpers shared by
// the clocked NCL ALU stage and its completeness detector.
package estagio_ula_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_D0   = 2'b01;
  localparam logic [1:0] DR_D1   = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  localparam logic [1:0] OP_SOMA = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  typedef enum logic {I_DATA, I_NULL} estado_in_t;
  typedef enum logic {O_NULL, O_DATA} estado_out_t;

  function automatic logic [1:0] dr_encode(input logic v);
    return v ? DR_D1 : DR_D0;
  endfunction

  function automatic logic dr_decode(input logic [1:0] p);
    return p == DR_D1;
  endfunction

  function automatic logic dr_completo(input logic [1:0] p);
    return (p == DR_D0) || (p == DR_D1);
  endfunction

endpackage

// File: rtl/estagio_ula_sinc_detector.sv
// Two-flop synchroniser for a dual-rail bus plus DATA/NULL completeness
// detection and a stability counter over consecutive identical samples.
module detector_completude
  import estagio_ula_pkg::*;
#(
  parameter int N          = 1,
  parameter int STABLE_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] din,
  output logic [2*N-1:0] amostra,
  output logic           dado_estavel,
  output logic           nulo_estavel,
  output logic           ilegal
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [2*N-1:0] s1_q, s2_q, ant_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   bit_completo, bit_ilegal;
  logic           completo, nulo;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign bit_completo[gi] = dr_completo(s2_q[2*gi +: 2]);
      assign bit_ilegal[gi]   = (s2_q[2*gi +: 2] == DR_ILL);
    end
  endgenerate

  assign completo = &bit_completo;
  assign nulo     = ~|s2_q;
  assign ilegal   = |bit_ilegal;

  // cnt_d is the run length of identical classified samples including the
  // current one; an illegal pair is neither complete nor NULL, so it pins 0.
  always_comb begin
    cnt_d = '0;
    if (completo || nulo) begin
      if (s2_q != ant_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CW'(STABLE_CYC)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  assign amostra      = s2_q;
  assign dado_estavel = completo && (cnt_d == CW'(STABLE_CYC));
  assign nulo_estavel = nulo && (cnt_d == CW'(STABLE_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      ant_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      ant_q <= s2_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/estagio_ula_sinc.sv
// Clocked NCL ALU stage: synchronised dual-rail operands in, FIFO-buffered
// dual-rail results out. Optional illegal-code detection: ESTAGIO_ULA_ILLEGAL_DET_EN.
module estagio_ula_sinc
  import estagio_ula_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 2,
  parameter int STABLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ack_in,
  input  logic [2*WIDTH-1:0]         a,
  input  logic [2*WIDTH-1:0]         b,
  input  logic [3:0]                 opr,
  output logic                       ack_out,
  output logic [2*WIDTH-1:0]         soma,
  output logic [1:0]                 of,
  output logic [1:0]                 zero,
  output logic [1:0]                 neg,
  output logic                       erro,
  output logic [$clog2(DEPTH+1)-1:0] ocupacao
);

  localparam int NB = 2*WIDTH + 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = WIDTH + 3;

  logic [2*NB-1:0] op_amostra;
  logic            op_dado_estavel, op_nulo_estavel, op_ilegal;
  logic [1:0]      ack_amostra;
  logic            ack_sinc;
  logic            ack_dado_unused, ack_nulo_unused, ack_ilegal_unused, ack_bit_unused;

  detector_completude #(.N(NB), .STABLE_CYC(STABLE_CYC)) u_det_op (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          ({opr, b, a}),
    .amostra      (op_amostra),
    .dado_estavel (op_dado_estavel),
    .nulo_estavel (op_nulo_estavel),
    .ilegal       (op_ilegal)
  );

  // ack_in is carried as a one-bit dual-rail pair so it shares the synchroniser.
  detector_completude #(.N(1), .STABLE_CYC(STABLE_CYC)) u_det_ack (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          ({ack_in, ~ack_in}),
    .amostra      (ack_amostra),
    .dado_estavel (ack_dado_unused),
    .nulo_estavel (ack_nulo_unused),
    .ilegal       (ack_ilegal_unused)
  );

  assign ack_sinc       = ack_amostra[1];
  assign ack_bit_unused = ack_amostra[0];

  logic [WIDTH-1:0] a_l, b_l, res;
  logic [1:0]       op_l;
  logic             ovf;
  logic [EW-1:0]    entrada, cabeca;
  logic [2*WIDTH-1:0] cabeca_dr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign a_l[gi] = dr_decode(op_amostra[2*gi +: 2]);
      assign b_l[gi] = dr_decode(op_amostra[2*WIDTH + 2*gi +: 2]);
      assign cabeca_dr[2*gi +: 2] = dr_encode(cabeca[gi]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_opr
      assign op_l[gi] = dr_decode(op_amostra[4*WIDTH + 2*gi +: 2]);
    end
  endgenerate

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (op_l)
      OP_SOMA: begin
        res = a_l + b_l;
        ovf = (a_l[WIDTH-1] == b_l[WIDTH-1]) && (res[WIDTH-1] != a_l[WIDTH-1]);
      end
      OP_SUB: begin
        res = a_l - b_l;
        ovf = (a_l[WIDTH-1] != b_l[WIDTH-1]) && (res[WIDTH-1] != a_l[WIDTH-1]);
      end
      OP_AND: res = a_l & b_l;
      OP_XOR: res = a_l ^ b_l;
    endcase
  end

  // FIFO entry layout: {neg, zero, of, result}
  assign entrada = {res[WIDTH-1], (res == '0), ovf, res};

  estado_in_t  estado_in_q, estado_in_d;
  estado_out_t estado_out_q, estado_out_d;
  logic        push, pop;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ocup_q, ocup_d;
  logic [EW-1:0] mem_q [DEPTH];

  always_comb begin
    estado_in_d = estado_in_q;
    push        = 1'b0;
    case (estado_in_q)
      I_DATA: if (op_dado_estavel && (ocup_q < CW'(DEPTH))) begin
        push        = 1'b1;
        estado_in_d = I_NULL;
      end
      I_NULL: if (op_nulo_estavel) estado_in_d = I_DATA;
      default: estado_in_d = I_DATA;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    if (push && !pop)      ocup_d = ocup_q + CW'(1);
    else if (pop && !push) ocup_d = ocup_q - CW'(1);
  end

  assign cabeca = mem_q[rd_ptr_q];

  logic [2*WIDTH-1:0] soma_q, soma_d;
  logic [1:0]         of_q, of_d, zero_q, zero_d, neg_q, neg_d;

  always_comb begin
    estado_out_d = estado_out_q;
    soma_d       = soma_q;
    of_d         = of_q;
    zero_d       = zero_q;
    neg_d        = neg_q;
    pop          = 1'b0;
    case (estado_out_q)
      O_NULL: if ((ocup_q != '0) && ack_sinc) begin
        soma_d       = cabeca_dr;
        of_d         = dr_encode(cabeca[WIDTH]);
        zero_d       = dr_encode(cabeca[WIDTH+1]);
        neg_d        = dr_encode(cabeca[WIDTH+2]);
        estado_out_d = O_DATA;
      end
      O_DATA: if (!ack_sinc) begin
        soma_d       = '0;
        of_d         = DR_NULL;
        zero_d       = DR_NULL;
        neg_d        = DR_NULL;
        pop          = 1'b1;
        estado_out_d = O_NULL;
      end
      default: estado_out_d = O_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entrada;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_in_q  <= I_DATA;
      estado_out_q <= O_NULL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ocup_q       <= '0;
      soma_q       <= '0;
      of_q         <= DR_NULL;
      zero_q       <= DR_NULL;
      neg_q        <= DR_NULL;
    end else begin
      estado_in_q  <= estado_in_d;
      estado_out_q <= estado_out_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ocup_q       <= ocup_d;
      soma_q       <= soma_d;
      of_q         <= of_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
    end
  end

`ifdef ESTAGIO_ULA_ILLEGAL_DET_EN
  logic erro_q, erro_d;
  assign erro_d = erro_q | op_ilegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) erro_q <= 1'b0;
    else        erro_q <= erro_d;
  end
  assign erro = erro_q;
`else
  logic ilegal_unused;
  assign ilegal_unused = op_ilegal;
  assign erro = 1'b0;
`endif

  assign ack_out  = (estado_in_q == I_DATA);
  assign soma     = soma_q;
  assign of       = of_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign ocupacao = ocup_q;

endmodule
